// File: rtl/note_pkg.sv
// Shared slot-state encoding and default playfield geometry for the note pool.
package note_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FALL = 2'd1,
    ST_HIT  = 2'd2,
    ST_MISS = 2'd3
  } slot_st_t;

  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned SQ_SIZE   = 32;
  localparam int unsigned X_BASE    = 192;
  localparam int unsigned COL_PITCH = 64;
  localparam int unsigned HIT_Y     = 416;
  localparam int unsigned HIT_WIN   = 24;

endpackage

// File: rtl/note_pool_if.sv
// Note pool bus: sequencer/button requests in, packed rectangles, slot states and events out.
interface note_pool_if #(
  parameter int unsigned NOTES   = 4,
  parameter int unsigned COL_W   = 2,
  parameter int unsigned SPEED_W = 8,
  parameter int unsigned COORD_W = 12
);
  logic                     i_ani_stb;
  logic                     i_animate;
  logic                     i_spawn;
  logic [COL_W-1:0]         i_spawn_col;
  logic [SPEED_W-1:0]       i_speed;
  logic                     i_hit;
  logic [COL_W-1:0]         i_hit_col;
  logic [NOTES*COORD_W-1:0] o_x1;
  logic [NOTES*COORD_W-1:0] o_x2;
  logic [NOTES*COORD_W-1:0] o_y1;
  logic [NOTES*COORD_W-1:0] o_y2;
  logic [NOTES*2-1:0]       o_state;
  logic                     o_full;
  logic                     o_hit;
  logic                     o_miss;
  logic                     o_drop;
  logic                     o_bad;

  modport master (
    output i_ani_stb, i_animate, i_spawn, i_spawn_col, i_speed, i_hit, i_hit_col,
    input  o_x1, o_x2, o_y1, o_y2, o_state, o_full, o_hit, o_miss, o_drop, o_bad
  );

  modport slave (
    input  i_ani_stb, i_animate, i_spawn, i_spawn_col, i_speed, i_hit, i_hit_col,
    output o_x1, o_x2, o_y1, o_y2, o_state, o_full, o_hit, o_miss, o_drop, o_bad
  );
endinterface

// File: rtl/note_slot.sv
// One falling-note slot: state FSM, rectangle coordinates, latched lane and speed.
module note_slot
  import note_pkg::*;
#(
  parameter int unsigned COL_W     = 2,
  parameter int unsigned SPEED_W   = 8,
  parameter int unsigned COORD_W   = 12,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned SQ_SIZE   = 32,
  parameter int unsigned X_BASE    = 192,
  parameter int unsigned COL_PITCH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [COL_W-1:0]   load_col,
  input  logic [SPEED_W-1:0] load_speed,
  input  logic               step,
  input  logic               judge,
  output slot_st_t           state,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] x2,
  output logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] y2,
  output logic [COL_W-1:0]   col,
  output logic               miss
);

  slot_st_t           state_nx;
  logic [COORD_W-1:0] x1_nx, x2_nx, y1_nx, y2_nx, y1_step;
  logic [COL_W-1:0]   col_nx;
  logic [SPEED_W-1:0] spd, spd_nx;

  assign y1_step = y1 + COORD_W'(spd);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      x1    <= '0;
      x2    <= '0;
      y1    <= '0;
      y2    <= '0;
      col   <= '0;
      spd   <= '0;
    end else begin
      state <= state_nx;
      x1    <= x1_nx;
      x2    <= x2_nx;
      y1    <= y1_nx;
      y2    <= y2_nx;
      col   <= col_nx;
      spd   <= spd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    x1_nx    = x1;
    x2_nx    = x2;
    y1_nx    = y1;
    y2_nx    = y2;
    col_nx   = col;
    spd_nx   = spd;
    miss     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          state_nx = ST_FALL;
          x1_nx    = COORD_W'(X_BASE) + COORD_W'(load_col) * COORD_W'(COL_PITCH);
          x2_nx    = x1_nx + COORD_W'(SQ_SIZE);
          y1_nx    = '0;
          y2_nx    = COORD_W'(SQ_SIZE);
          col_nx   = load_col;
          spd_nx   = (load_speed == '0) ? SPEED_W'(1) : load_speed;
        end
      end
      ST_FALL: begin
        // A judged note freezes at its pre-step position.
        if (judge) begin
          state_nx = ST_HIT;
        end else if (step) begin
          y1_nx = y1_step;
          y2_nx = y2 + COORD_W'(spd);
          if (y1_step >= COORD_W'(SCREEN_H)) begin
            state_nx = ST_MISS;
            miss     = 1'b1;
          end
        end
      end
      ST_HIT, ST_MISS: begin
        if (step) begin
          state_nx = ST_IDLE;
          x1_nx    = '0;
          x2_nx    = '0;
          y1_nx    = '0;
          y2_nx    = '0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/note_pool.sv
// Pool of NOTES falling notes: spawn allocation, hit judging and event pulses.
// Build option: NOTE_POOL_BADPRESS_EN enables the o_bad pulse for presses with no candidate.
module note_pool
  import note_pkg::*;
#(
  parameter int unsigned NOTES     = 4,
  parameter int unsigned COL_W     = 2,
  parameter int unsigned SPEED_W   = 8,
  parameter int unsigned COORD_W   = 12,
  parameter int unsigned SCREEN_H  = note_pkg::SCREEN_H,
  parameter int unsigned SQ_SIZE   = note_pkg::SQ_SIZE,
  parameter int unsigned X_BASE    = note_pkg::X_BASE,
  parameter int unsigned COL_PITCH = note_pkg::COL_PITCH,
  parameter int unsigned HIT_Y     = note_pkg::HIT_Y,
  parameter int unsigned HIT_WIN   = note_pkg::HIT_WIN
) (
  input  logic       i_clk,
  input  logic       i_rst,
  note_pool_if.slave bus
);

  localparam logic [COORD_W:0] WIN_LO  = (COORD_W+1)'(HIT_Y - HIT_WIN);
  localparam logic [COORD_W:0] WIN_HI  = (COORD_W+1)'(HIT_Y + HIT_WIN);
  localparam logic [COORD_W:0] SQ_HALF = (COORD_W+1)'(SQ_SIZE / 2);

  slot_st_t           st  [NOTES];
  logic [COORD_W-1:0] x1  [NOTES];
  logic [COORD_W-1:0] x2  [NOTES];
  logic [COORD_W-1:0] y1  [NOTES];
  logic [COORD_W-1:0] y2  [NOTES];
  logic [COL_W-1:0]   col [NOTES];
  logic [NOTES-1:0]   load, judge, miss_ev, idle;
  logic               step, any_idle, judged;

  assign step = bus.i_ani_stb & bus.i_animate;

  for (genvar k = 0; k < NOTES; k++) begin : g_slot
    note_slot #(
      .COL_W    (COL_W),
      .SPEED_W  (SPEED_W),
      .COORD_W  (COORD_W),
      .SCREEN_H (SCREEN_H),
      .SQ_SIZE  (SQ_SIZE),
      .X_BASE   (X_BASE),
      .COL_PITCH(COL_PITCH)
    ) u_slot (
      .clk       (i_clk),
      .rst       (i_rst),
      .load      (load[k]),
      .load_col  (bus.i_spawn_col),
      .load_speed(bus.i_speed),
      .step      (step),
      .judge     (judge[k]),
      .state     (st[k]),
      .x1        (x1[k]),
      .x2        (x2[k]),
      .y1        (y1[k]),
      .y2        (y2[k]),
      .col       (col[k]),
      .miss      (miss_ev[k])
    );
    assign idle[k] = (st[k] == ST_IDLE);
  end

  always_comb begin
    bus.o_x1    = '0;
    bus.o_x2    = '0;
    bus.o_y1    = '0;
    bus.o_y2    = '0;
    bus.o_state = '0;
    for (int unsigned k = 0; k < NOTES; k++) begin
      bus.o_x1[k*COORD_W +: COORD_W] = x1[k];
      bus.o_x2[k*COORD_W +: COORD_W] = x2[k];
      bus.o_y1[k*COORD_W +: COORD_W] = y1[k];
      bus.o_y2[k*COORD_W +: COORD_W] = y2[k];
      bus.o_state[k*2 +: 2]          = st[k];
    end
  end

  assign any_idle   = |idle;
  assign bus.o_full = ~any_idle;

  // Spawn goes to the lowest-index IDLE slot.
  always_comb begin
    logic found;
    found = 1'b0;
    load  = '0;
    for (int unsigned k = 0; k < NOTES; k++) begin
      if (!found && idle[k]) begin
        found   = 1'b1;
        load[k] = bus.i_spawn;
      end
    end
  end

  // Deepest candidate wins; strict '>' keeps the lowest index on a tie.
  always_comb begin
    logic [COORD_W:0]   ctr;
    logic [COORD_W-1:0] best;
    judge  = '0;
    judged = 1'b0;
    best   = '0;
    ctr    = '0;
    for (int unsigned k = 0; k < NOTES; k++) begin
      ctr = {1'b0, y1[k]} + SQ_HALF;
      if (bus.i_hit && st[k] == ST_FALL && col[k] == bus.i_hit_col &&
          ctr >= WIN_LO && ctr <= WIN_HI && (!judged || y1[k] > best)) begin
        judged   = 1'b1;
        best     = y1[k];
        judge    = '0;
        judge[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_hit  <= 1'b0;
      bus.o_miss <= 1'b0;
      bus.o_drop <= 1'b0;
    end else begin
      bus.o_hit  <= judged;
      bus.o_miss <= |miss_ev;
      bus.o_drop <= bus.i_spawn & ~any_idle;
    end
  end

`ifdef NOTE_POOL_BADPRESS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) bus.o_bad <= 1'b0;
    else       bus.o_bad <= bus.i_hit & ~judged;
  end
`else
  assign bus.o_bad = 1'b0;
`endif

endmodule

// File: tb/tb_note_pool.sv
// Scoreboard bench for note_pool: a note-list model predicts every post-edge snapshot.
module tb_note_pool;
  localparam int NOTES   = 4;
  localparam int COL_W   = 2;
  localparam int SPEED_W = 8;
  localparam int COORD_W = 12;

  typedef struct packed {
    logic [2*NOTES-1:0]       st;
    logic [NOTES*COORD_W-1:0] x1;
    logic [NOTES*COORD_W-1:0] x2;
    logic [NOTES*COORD_W-1:0] y1;
    logic [NOTES*COORD_W-1:0] y2;
    logic                     full;
    logic                     hit;
    logic                     miss;
    logic                     drop;
    logic                     bad;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  note_pool_if #(.NOTES(NOTES), .COL_W(COL_W), .SPEED_W(SPEED_W), .COORD_W(COORD_W)) bus ();

  note_pool #(.NOTES(NOTES), .COL_W(COL_W), .SPEED_W(SPEED_W), .COORD_W(COORD_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  snap_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  int cyc_no     = 0;

  // Model: 0 idle, 1 falling, 2 hit, 3 missed; x2/y2 are always x1/y1 + 32 when live.
  int m_st [NOTES];
  int m_x1 [NOTES];
  int m_y1 [NOTES];
  int m_col[NOTES];
  int m_spd[NOTES];

  task automatic cyc(input bit r, input bit stb, input bit anim, input bit sp,
                     input int scol, input int spd, input bit h, input int hcol);
    int    best, fs, d;
    bit    ev_miss, full;
    snap_t e;
    @(negedge clk);
    rst               = r;
    bus.i_ani_stb     = stb;
    bus.i_animate     = anim;
    bus.i_spawn       = sp;
    bus.i_spawn_col   = COL_W'(scol);
    bus.i_speed       = SPEED_W'(spd);
    bus.i_hit         = h;
    bus.i_hit_col     = COL_W'(hcol);
    e       = '0;
    best    = -1;
    fs      = -1;
    ev_miss = 1'b0;
    if (r) begin
      for (int i = 0; i < NOTES; i++) m_st[i] = 0;
    end else begin
      for (int i = 0; i < NOTES; i++) begin
        if (h && m_st[i] == 1 && m_col[i] == hcol) begin
          d = m_y1[i] + 16 - 416;
          if (d < 0) d = -d;
          if (d <= 24 && (best < 0 || m_y1[i] > m_y1[best])) best = i;
        end
        if (fs < 0 && m_st[i] == 0) fs = i;
      end
      for (int i = 0; i < NOTES; i++) begin
        if (i == best) m_st[i] = 2;
        else if (m_st[i] == 1 && stb && anim) begin
          m_y1[i] += m_spd[i];
          if (m_y1[i] >= 480) begin
            m_st[i] = 3;
            ev_miss = 1'b1;
          end
        end else if (m_st[i] >= 2 && stb && anim) m_st[i] = 0;
      end
      if (sp && fs >= 0) begin
        m_st[fs]  = 1;
        m_col[fs] = scol;
        m_x1[fs]  = 192 + scol * 64;
        m_y1[fs]  = 0;
        m_spd[fs] = (spd == 0) ? 1 : spd;
      end
      e.hit  = (best >= 0);
      e.miss = ev_miss;
      e.drop = sp && (fs < 0);
`ifdef NOTE_POOL_BADPRESS_EN
      e.bad  = h && (best < 0);
`endif
    end
    full = 1'b1;
    for (int i = 0; i < NOTES; i++) begin
      e.st[2*i +: 2] = 2'(m_st[i]);
      if (m_st[i] != 0) begin
        e.x1[i*COORD_W +: COORD_W] = COORD_W'(m_x1[i]);
        e.x2[i*COORD_W +: COORD_W] = COORD_W'(m_x1[i] + 32);
        e.y1[i*COORD_W +: COORD_W] = COORD_W'(m_y1[i]);
        e.y2[i*COORD_W +: COORD_W] = COORD_W'(m_y1[i] + 32);
      end else full = 1'b0;
    end
    e.full = full;
    exp_q.push_back(e);
  endtask

  task automatic steps(input int n);
    repeat (n) cyc(0, 1, 1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every edge yields a snapshot; pop its prediction and compare.
  initial begin
    snap_t a, e;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.o_state, bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2,
             bus.o_full, bus.o_hit, bus.o_miss, bus.o_drop, bus.o_bad};
        compared++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL snapshot cycle %0d: got st=%h x1=%h y1=%h y2=%h f/h/m/d/b=%b%b%b%b%b, want st=%h x1=%h y1=%h y2=%h f/h/m/d/b=%b%b%b%b%b",
                   cyc_no, a.st, a.x1, a.y1, a.y2, a.full, a.hit, a.miss, a.drop, a.bad,
                   e.st, e.x1, e.y1, e.y2, e.full, e.hit, e.miss, e.drop, e.bad);
        end
      end
    end
  end

  initial begin
    bus.i_ani_stb   = 1'b0;
    bus.i_animate   = 1'b0;
    bus.i_spawn     = 1'b0;
    bus.i_spawn_col = '0;
    bus.i_speed     = '0;
    bus.i_hit       = 1'b0;
    bus.i_hit_col   = '0;
    for (int i = 0; i < NOTES; i++) begin
      m_st[i] = 0; m_x1[i] = 0; m_y1[i] = 0; m_col[i] = 0; m_spd[i] = 0;
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 4, 1, 1);

    // Spawn, fall to 400, ignored strobes, judged press, release to IDLE.
    cyc(0, 0, 0, 1, 1, 4, 0, 0);
    steps(100);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    steps(2);

    // Unpressed note runs off the bottom.
    cyc(0, 0, 0, 1, 2, 4, 0, 0);
    steps(121);

    // Fill the pool, then one more spawn is dropped.
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, i % 4, i * 3, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);

    // Two lane-0 notes at 400 and 380; press coincides with a step.
    cyc(0, 0, 0, 1, 0, 4, 0, 0);
    steps(5);
    cyc(0, 0, 0, 1, 0, 4, 0, 0);
    steps(95);
    cyc(0, 1, 1, 0, 0, 0, 1, 0);
    steps(4);

    // Press on an empty lane, speed-0 spawn, reset mid-fall.
    cyc(0, 0, 0, 0, 0, 0, 1, 3);
    cyc(0, 0, 0, 1, 3, 0, 0, 0);
    steps(10);
    cyc(1, 1, 1, 1, 2, 5, 1, 3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (4000) begin
      cyc($urandom_range(0, 799) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0,
          $urandom_range(0, 9) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
          $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
